// File: rtl/tsense_pkg.sv
// tsense_ctrl shared types: FSM state enum and signed saturation helper.
// Used by tsense_ctrl and its testbench (TSENSE_AVG_EN selects averaging).
package tsense_pkg;

   typedef enum logic [1:0] {
      S_OFF,
      S_PWRUP,
      S_RESET,
      S_INTEGRATE
   } tsense_state_t;

   // Clamp v to the signed range of a w-bit value.
   function automatic logic signed [63:0] sat_s(
      input logic signed [63:0] v,
      input int                 w
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/tsense_ctrl_sync.sv
// DO_1V8 synchroniser: two flops into the clk domain plus a
// rising-edge detector; o_det pulses one cycle per edge.
module tsense_ctrl_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_det
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Metastability chain plus one delayed copy for edge detection.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_det = r_s2 & ~r_s3;

endmodule

// File: rtl/tsense_ctrl.sv
// GR-EX temperature sensor sequencer: power-up, reset/integrate loop,
// timeout, optional averaging (TSENSE_AVG_EN) and saturated conversion.
module tsense_ctrl
   import tsense_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int AVG_LOG2   = 2,
   parameter int T_PWRUP    = 10,
   parameter int T_RESET    = 15,
   parameter int CNT_OFFSET = 65,
   parameter int SLOPE      = -6,
   parameter int TEMP_BIAS  = 20,
   parameter int TEMP_W     = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     DO_1V8,
   output logic                     RESET_1V8,
   output logic                     PWRUP_1V8,
   output logic [CNT_W-1:0]         counter,
   output logic signed [TEMP_W-1:0] temperature,
   output logic                     valid,
   output logic                     timeout,
   output logic                     busy
);

   localparam int T_MAX = (T_PWRUP > T_RESET) ? T_PWRUP : T_RESET;
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam int CW    = CNT_W + 16;

   tsense_state_t r_state;
   tsense_state_t w_next;

   logic [TMR_W-1:0]         r_tmr;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         r_counter;
   logic [CNT_W-1:0]         r_avg;
   logic                     r_go;
   logic                     r_valid;
   logic                     r_timeout;
   logic signed [TEMP_W-1:0] r_temp;

   logic                     w_det;
   logic                     w_integ;
   logic                     w_fin;
   logic                     w_to;
   logic                     w_end;
   logic                     w_tmr_done;
   logic                     w_done;
   logic [CNT_W-1:0]         w_avg;
   logic signed [CW-1:0]     w_avg_s;
   logic signed [CW-1:0]     w_prod;
   logic signed [TEMP_W-1:0] w_temp;

   tsense_ctrl_sync u_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (DO_1V8),
      .o_det (w_det)
   );

   assign w_integ = (r_state == S_INTEGRATE);
   assign w_fin   = w_integ & w_det;
   assign w_to    = w_integ & ~w_det & (&r_cnt);
   assign w_end   = w_fin | w_to;

   assign w_tmr_done =
      ((r_state == S_PWRUP) && (r_tmr == TMR_W'(T_PWRUP - 1))) ||
      ((r_state == S_RESET) && (r_tmr == TMR_W'(T_RESET - 1)));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_OFF;
      else
         r_state <= w_next;
   end

   // Next-state and sensor control outputs.
   always_comb begin
      w_next    = r_state;
      RESET_1V8 = 1'b1;
      PWRUP_1V8 = 1'b0;
      unique case (r_state)
         S_OFF: begin
            if (en)
               w_next = S_PWRUP;
         end
         S_PWRUP: begin
            PWRUP_1V8 = 1'b1;
            if (w_tmr_done)
               w_next = en ? S_RESET : S_OFF;
         end
         S_RESET: begin
            PWRUP_1V8 = 1'b1;
            if (w_tmr_done)
               w_next = en ? S_INTEGRATE : S_OFF;
         end
         S_INTEGRATE: begin
            RESET_1V8 = 1'b0;
            PWRUP_1V8 = 1'b1;
            if (w_end)
               w_next = en ? S_RESET : S_OFF;
         end
         default: w_next = S_OFF;
      endcase
   end

   // Phase timer restarts on every state change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_tmr <= '0;
      else if (r_state != w_next)
         r_tmr <= '0;
      else if (r_state == S_PWRUP || r_state == S_RESET)
         r_tmr <= r_tmr + 1'b1;
   end

   // Integration counter: cleared in S_RESET, holds on det/timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (r_state == S_RESET)
         r_cnt <= '0;
      else if (w_integ && !w_det && !w_to)
         r_cnt <= r_cnt + 1'b1;
   end

`ifdef TSENSE_AVG_EN
   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] r_acc;
   logic [IDX_W-1:0] r_idx;
   logic [ACC_W-1:0] w_sum;
   logic             w_last;

   assign w_sum  = r_acc + ACC_W'(r_cnt);
   assign w_last = (r_idx == IDX_W'((1 << AVG_LOG2) - 1));
   assign w_avg  = CNT_W'(w_sum >> AVG_LOG2);
   assign w_done = w_fin & w_last;

   // Accumulator; a timeout throws away the partial average.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (w_to) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (w_fin) begin
         if (w_last) begin
            r_acc <= '0;
            r_idx <= '0;
         end else begin
            r_acc <= w_sum;
            r_idx <= r_idx + 1'b1;
         end
      end
   end
`else
   assign w_avg  = r_cnt;
   assign w_done = w_fin;
`endif

   assign w_avg_s = $signed({16'd0, r_avg});
   assign w_prod  = (w_avg_s - CW'(CNT_OFFSET)) * CW'(SLOPE)
                  + CW'(TEMP_BIAS);
   assign w_temp  = TEMP_W'(sat_s(64'(w_prod), TEMP_W));

   // Result pipeline: sample at D, temperature at D+1, valid in D+2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_counter <= '0;
         r_avg     <= '0;
         r_go      <= 1'b0;
         r_valid   <= 1'b0;
         r_temp    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_go    <= w_done;
         r_valid <= r_go;
         if (w_fin)
            r_counter <= r_cnt;
         if (w_done)
            r_avg <= w_avg;
         if (r_go)
            r_temp <= w_temp;
         if (w_to)
            r_timeout <= 1'b1;
      end
   end

   assign counter     = r_counter;
   assign temperature = r_temp;
   assign valid       = r_valid;
   assign timeout     = r_timeout;
   assign busy        = (r_state != S_OFF);

endmodule

// File: tb/tb_tsense_ctrl.sv
// Scoreboard bench for tsense_ctrl; expected results are queued at
// stimulus time and popped by a monitor on each valid pulse.
module tb_tsense_ctrl;

`ifdef TSENSE_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   typedef struct {
      int t;
      int c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] en_v = '0;
   logic [2:0] do_v = '0;

   wire [2:0]         w_rst18;
   wire [2:0]         w_pw18;
   wire [2:0]         w_valid;
   wire [2:0]         w_to;
   wire [2:0]         w_busy;
   wire [7:0]         cnt0;
   wire [7:0]         cnt1;
   wire [7:0]         cnt2;
   wire signed [11:0] t0;
   wire signed [7:0]  t1;
   wire signed [7:0]  t2;

   int   total = 0;
   int   bad = 0;
   int   rl_err = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   tsense_ctrl u0 (
      .clk(clk), .reset(reset), .en(en_v[0]), .DO_1V8(do_v[0]),
      .RESET_1V8(w_rst18[0]), .PWRUP_1V8(w_pw18[0]),
      .counter(cnt0), .temperature(t0), .valid(w_valid[0]),
      .timeout(w_to[0]), .busy(w_busy[0])
   );

   tsense_ctrl #(.TEMP_W(8)) u1 (
      .clk(clk), .reset(reset), .en(en_v[1]), .DO_1V8(do_v[1]),
      .RESET_1V8(w_rst18[1]), .PWRUP_1V8(w_pw18[1]),
      .counter(cnt1), .temperature(t1), .valid(w_valid[1]),
      .timeout(w_to[1]), .busy(w_busy[1])
   );

   tsense_ctrl #(.TEMP_W(8), .CNT_OFFSET(0)) u2 (
      .clk(clk), .reset(reset), .en(en_v[2]), .DO_1V8(do_v[2]),
      .RESET_1V8(w_rst18[2]), .PWRUP_1V8(w_pw18[2]),
      .counter(cnt2), .temperature(t2), .valid(w_valid[2]),
      .timeout(w_to[2]), .busy(w_busy[2])
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic push(input int sel, input int t, input int c);
      exp_t e;
      e.t = t;
      e.c = c;
      case (sel)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic mon(input int sel, input int t, input int c);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (sel)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default:
            if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         total++;
         bad++;
         $display("FAIL valid%0d: unexpected pulse temp=%0d cnt=%0d",
                  sel, t, c);
      end else begin
         chk($sformatf("temp%0d", sel), t, e.t);
         chk($sformatf("cnt%0d", sel), c, e.c);
      end
   endtask

   always @(negedge clk) begin
      if (w_valid[0]) mon(0, int'(t0), int'(cnt0));
      if (w_valid[1]) mon(1, int'(t1), int'(cnt1));
      if (w_valid[2]) mon(2, int'(t2), int'(cnt2));
   end

   // One conversion with det at count c. Called either in the first
   // S_PWRUP cycle (first=1) or in the first S_RESET cycle; returns in
   // the cycle after det, i.e. the first cycle of the next phase.
   task automatic conv(input int sel, input int c, input bit first,
                       input bit exp_push, input int t, input bit drop);
      int n;
      n = first ? 23 + c : 13 + c;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (first && sel == 0) begin
            if (w_rst18[0] != (i < 25) || w_pw18[0] != 1'b1)
               rl_err++;
         end
      end
      if (exp_push)
         push(sel, t, c);
      do_v[sel] = 1'b1;
      if (drop)
         en_v[sel] = 1'b0;
      repeat (3) @(negedge clk);
      do_v[sel] = 1'b0;
   endtask

   task automatic grp(input int sel, input bit first,
                      input int c0, input int c1, input int c2,
                      input int c3, input int u0v, input int u1v,
                      input int u2v, input int u3v, input int ta);
      conv(sel, c0, first, !AVG, u0v, 1'b0);
      conv(sel, c1, 1'b0, !AVG, u1v, 1'b0);
      conv(sel, c2, 1'b0, !AVG, u2v, 1'b0);
      conv(sel, c3, 1'b0, 1'b1, AVG ? ta : u3v, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rst18"}, int'(w_rst18[0]), 1);
      chk({tag, "_pw18"}, int'(w_pw18[0]), 0);
      chk({tag, "_cnt"}, int'(cnt0), 0);
      chk({tag, "_temp"}, int'(t0), 0);
      chk({tag, "_valid"}, int'(w_valid[0]), 0);
      chk({tag, "_timeout"}, int'(w_to[0]), 0);
      chk({tag, "_busy"}, int'(w_busy[0]), 0);
   endtask

   initial begin
      #23;
      chk_reset("por");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      en_v[0] = 1'b1;
      @(negedge clk);
      chk("pwrup_rise", int'(w_pw18[0]), 1);
      chk("busy_on", int'(w_busy[0]), 1);

      grp(0, 1'b1, 65, 65, 65, 65, 20, 20, 20, 20, 20);
      grp(0, 1'b0, 70, 70, 71, 71, -10, -10, -16, -16, -10);

      chk("timeout_pre", int'(w_to[0]), 0);
      repeat (271) @(negedge clk);
      chk("timeout_set", int'(w_to[0]), 1);
      chk("timeout_idle", int'(w_rst18[0]), 1);
      grp(0, 1'b0, 65, 65, 65, 65, 20, 20, 20, 20, 20);
      chk("timeout_sticky", int'(w_to[0]), 1);

      conv(0, 80, 1'b0, !AVG, -70, 1'b1);
      chk("drop_pw18", int'(w_pw18[0]), 0);
      chk("drop_busy", int'(w_busy[0]), 0);
      repeat (3) @(negedge clk);
      en_v[0] = 1'b1;
      @(negedge clk);
      conv(0, 80, 1'b1, !AVG, -70, 1'b0);
      conv(0, 80, 1'b0, !AVG, -70, 1'b0);
      conv(0, 80, 1'b0, 1'b1, -70, 1'b0);
      chk("rst_len", rl_err, 0);

      repeat (20) @(negedge clk);
      chk("in_integrate", int'(w_rst18[0]), 0);
      #2 reset = 1'b1;
      #1 chk_reset("async");
      en_v[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      en_v[1] = 1'b1;
      @(negedge clk);
      grp(1, 1'b1, 0, 0, 0, 0, 127, 127, 127, 127, 127);
      en_v[1] = 1'b0;

      en_v[2] = 1'b1;
      @(negedge clk);
      grp(2, 1'b1, 255, 255, 255, 255, -128, -128, -128, -128, -128);
      en_v[2] = 1'b0;

      repeat (10) @(negedge clk);
      chk("drain0", q0.size(), 0);
      chk("drain1", q1.size(), 0);
      chk("drain2", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tsense_ctrl.md
# tsense_ctrl

Parametrised sequencer for the GR-EX analog temperature sensor. It powers up the sensor, then loops through reset and integrate phases on one clock. Each integration time is measured against the synchronised `DO_1V8` comparator output, optionally averaged over 2^AVG_LOG2 conversions, and converted to a signed temperature. It sits between the 1.8 V sensor macro and the digital register bank, and adds the following:
- enable control
- sample averaging
- timeout detection
- saturated output arithmetic

## Interface
- `CNT_W`, 8: integration counter width; timeout at 2^CNT_W-1
- `AVG_LOG2`, 2: log2 of samples averaged
- `T_PWRUP`, 10: cycles spent in S_PWRUP (≥1)
- `T_RESET`, 15: cycles spent in S_RESET (≥1)
- `CNT_OFFSET`, 65: count corresponding to `TEMP_BIAS`
- `SLOPE`, -6: signed degrees per count
- `TEMP_BIAS`, 20: temperature at `CNT_OFFSET`
- `TEMP_W`, 12: signed temperature width
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high reset
- `en` in 1: run conversions while high
- `DO_1V8` in 1: comparator output, asynchronous to `clk`
- `RESET_1V8` out 1: integrator reset to sensor
- `PWRUP_1V8` out 1: sensor power enable
- `counter` out CNT_W: last raw (unaveraged) count
- `temperature` out TEMP_W, signed: last converted temperature
- `valid` out 1: one-cycle pulse when `temperature` updates
- `timeout` out 1: sticky; set when a conversion times out
- `busy` out 1: high in any state except S_OFF

## Operation
- **Reset values.** `reset` high forces the following immediately:
  - state S_OFF
  - `RESET_1V8`=1, `PWRUP_1V8`=0
  - `counter`=0, `temperature`=0, `valid`=0, `timeout`=0
  - accumulator and sample index 0
  - synchroniser flops 0
- **DO detection.** `DO_1V8` passes through a 2-flop synchroniser plus a rising-edge detector; `det` is high for one cycle per rising edge.
- **S_OFF.**
  - Outputs: `RESET_1V8`=1, `PWRUP_1V8`=0.
  - `en`=1 → S_PWRUP.
- **S_PWRUP.**
  - Outputs: `RESET_1V8`=1, `PWRUP_1V8`=1.
  - Lasts exactly `T_PWRUP` cycles → S_RESET.
- **S_RESET.**
  - Outputs: `RESET_1V8`=1, `PWRUP_1V8`=1.
  - The integration count is cleared.
  - Lasts exactly `T_RESET` cycles → S_INTEGRATE.
- **S_INTEGRATE.**
  - Outputs: `RESET_1V8`=0, `PWRUP_1V8`=1.
  - Each cycle without `det`: count+1.
  - On `det`: the sample equals the count held in that cycle (not incremented).
  - `counter` ← sample; the sample is added to the accumulator; sample index +1.
  - Next state: S_RESET if `en`=1, else S_OFF.
- **Timeout.** Count = 2^CNT_W-1 with no `det`:
  - `timeout` ← 1; the sample is discarded.
  - Accumulator and sample index clear.
  - Next state: S_RESET if `en`=1, else S_OFF.
  - `det` in the same cycle wins over timeout.
- **Averaging.** Accumulator is CNT_W+AVG_LOG2 bits and cannot overflow. When the index reaches 2^AVG_LOG2:
  - avg = acc >> AVG_LOG2 (truncating);
  - accumulator and index clear.
- **Conversion.** temperature = (avg − CNT_OFFSET)·SLOPE + TEMP_BIAS.
  - Evaluated as signed at CNT_W+16 bits.
  - Saturated to the signed TEMP_W range.
- **`en` low.**
  - In S_PWRUP/S_RESET: → S_OFF at the end of the phase.
  - In S_INTEGRATE: the conversion completes first.
  - A partial average is kept across S_OFF.
- **`timeout` flag.** Cleared only by `reset`.

## Timing
- **Synchroniser latency.** A `DO_1V8` rising edge that meets setup before edge k gives `det` high in the cycle after edge k+1.
- **Result latency.** With `det` in cycle D:
  - `counter` updates at the end of D;
  - `temperature` updates and `valid` is registered at the end of D+1;
  - `valid` is high only during D+2.
- **Back-to-back conversions.** One conversion with `en` steady = `T_RESET` + integrate cycles + 0 gap; S_RESET begins in cycle D+1.
- **Edge placement.** A `det` occurring in S_RESET or S_PWRUP is ignored.

## Configuration
- `TSENSE_AVG_EN` defined: averaging exactly as above.
- Undefined:
  - `AVG_LOG2` is ignored; no accumulator is built;
  - every non-timeout sample converts directly (avg = sample);
  - `valid` pulses once per conversion with the same D+2 latency.

## Structure
- **`tsense_pkg`:**
  - state enum `tsense_state_t` {S_OFF, S_PWRUP, S_RESET, S_INTEGRATE};
  - the saturation helper function.
- **Sub-module `tsense_sync`:**
  - 2-flop synchroniser plus rising-edge detector;
  - async reset to 0; output `det`.
- Top holds:
  - FSM
  - phase timer (width covers max(T_PWRUP, T_RESET))
  - integration counter
  - accumulator
  - conversion register

## Test plan
- Reset, `en`=1:
  - `PWRUP_1V8` rises the cycle after S_OFF exit;
  - `RESET_1V8` stays 1 for exactly 10+15 cycles;
  - `RESET_1V8` then falls.
- Four conversions with `det` at count 65 → `counter`=65, `temperature`=20, a single `valid` pulse after the 4th.
- Counts 70, 70, 71, 71 → avg 70, `temperature`=−10.
  - With the macro undefined: four pulses, values −10, −10, −16, −16.
- `DO_1V8` held low → after 255 integrate cycles:
  - `timeout`=1;
  - no `valid`;
  - next conversion (`det` at 65, four times) still yields 20 and `timeout` stays 1.
- Count 0 with SLOPE=−6, TEMP_W=8 → 410 saturates to 127; `CNT_OFFSET`=0, count 255 → −1510 saturates to −128.
- `en` dropped mid-integrate → the conversion completes, then S_OFF (`PWRUP_1V8`=0).
- Async `reset` pulse mid-S_INTEGRATE → all outputs take their reset values without a clock edge.
